// File: rtl/adc_trigger_capture.sv
// Trigger-and-capture buffer for the adc sample stream: circular pre-trigger history,
// level-crossing or forced trigger, then an oldest-first valid/ready readout of one frame.
module adc_trigger_capture #(
   parameter int DATA_W   = 8,
   parameter int DEPTH    = 1024,
   parameter int PRE_TRIG = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] din,
   input  logic              din_valid,
   input  logic              arm,
   input  logic [DATA_W-1:0] trig_level,
   input  logic              trig_edge,
   input  logic              force_trig,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic              busy,
   output logic              triggered
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] PRE_N   = CW'(PRE_TRIG);
   localparam logic [CW-1:0] POST_N  = CW'(DEPTH - PRE_TRIG);
   localparam logic [AW-1:0] PRE_OFF = AW'(PRE_TRIG);
   localparam logic [AW-1:0] LAST_N  = AW'(DEPTH - 1);

   typedef enum logic [2:0] {IDLE, PRE, WAIT, POST, READ} state_t;

   state_t            state;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr, trig_ptr, rd_cnt;
   logic [CW-1:0]     pre_cnt, post_cnt;
   logic [DATA_W-1:0] prev;
   logic              prev_valid, force_pend;
   logic              wr_en;

   function automatic logic crossing(input logic [DATA_W-1:0] p, input logic [DATA_W-1:0] c,
                                     input logic [DATA_W-1:0] lvl, input logic falling);
      if (falling) return (p >= lvl) && (c < lvl);
      else         return (p < lvl) && (c >= lvl);
   endfunction

   // arm takes priority over a coincident sample, so that sample never lands in the buffer
   assign wr_en = din_valid && !arm && !rst && (state == PRE || state == WAIT || state == POST);

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         trig_ptr   <= '0;
         rd_cnt     <= '0;
         pre_cnt    <= '0;
         post_cnt   <= '0;
         prev_valid <= 1'b0;
         force_pend <= 1'b0;
         out_data   <= '0;
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
         busy       <= 1'b0;
         triggered  <= 1'b0;
      end else if (arm) begin
         state      <= PRE;
         wr_ptr     <= '0;
         rd_cnt     <= '0;
         pre_cnt    <= '0;
         post_cnt   <= '0;
         prev_valid <= 1'b0;
         force_pend <= 1'b0;
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
         busy       <= 1'b1;
         triggered  <= 1'b0;
      end else begin
         case (state)
            IDLE: ;
            PRE: begin
               if (din_valid) begin
                  wr_ptr     <= wr_ptr + AW'(1);
                  pre_cnt    <= pre_cnt + CW'(1);
                  prev       <= din;
                  prev_valid <= 1'b1;
                  if (pre_cnt + CW'(1) == PRE_N) state <= WAIT;
               end
            end
            WAIT: begin
               if (din_valid) begin
                  wr_ptr     <= wr_ptr + AW'(1);
                  prev       <= din;
                  prev_valid <= 1'b1;
                  if (force_trig || force_pend ||
                      (prev_valid && crossing(prev, din, trig_level, trig_edge))) begin
                     trig_ptr   <= wr_ptr;
                     triggered  <= 1'b1;
                     post_cnt   <= CW'(1);
                     force_pend <= 1'b0;
                     if (POST_N == CW'(1)) begin
                        state  <= READ;
                        rd_ptr <= wr_ptr - PRE_OFF;
                        rd_cnt <= '0;
                     end else begin
                        state <= POST;
                     end
                  end
               end else if (force_trig) begin
                  force_pend <= 1'b1;
               end
            end
            POST: begin
               if (din_valid) begin
                  wr_ptr   <= wr_ptr + AW'(1);
                  prev     <= din;
                  post_cnt <= post_cnt + CW'(1);
                  if (post_cnt + CW'(1) == POST_N) begin
                     state  <= READ;
                     rd_ptr <= trig_ptr - PRE_OFF;
                     rd_cnt <= '0;
                  end
               end
            end
            READ: begin
               // the output register doubles as the BRAM read register; it reloads only when free
               if (out_valid && out_ready && out_last) begin
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end else if (!out_valid || out_ready) begin
                  out_data  <= mem[rd_ptr];
                  out_valid <= 1'b1;
                  out_last  <= (rd_cnt == LAST_N);
                  rd_ptr    <= rd_ptr + AW'(1);
                  rd_cnt    <= rd_cnt + AW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_adc_trigger_capture.sv
// Directed bench for adc_trigger_capture with DEPTH=16, PRE_TRIG=4 and a 0x80 trigger level.
module tb_adc_trigger_capture;

   logic       clk = 1'b0;
   logic       rst, din_valid, arm, trig_edge, force_trig, out_ready;
   logic [7:0] din, trig_level;
   logic [7:0] out_data;
   logic       out_valid, out_last, busy, triggered;

   int n_cmp  = 0;
   int n_fail = 0;
   logic [7:0] exp_q [16];

   adc_trigger_capture #(.DATA_W(8), .DEPTH(16), .PRE_TRIG(4)) dut (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .arm(arm),
      .trig_level(trig_level), .trig_edge(trig_edge), .force_trig(force_trig),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .busy(busy), .triggered(triggered)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic sample(input logic [7:0] v);
      din = v;
      din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
      tick();
   endtask

   task automatic do_arm();
      arm = 1'b1;
      tick();
      arm = 1'b0;
      tick();
   endtask

   task automatic read_frame(input string tag, input bit bp);
      int k = 0;
      int cyc = 0;
      bit tog = 1'b0;
      bit stalled = 1'b0;
      logic [7:0] held = '0;
      logic       held_last = 1'b0;
      while (k < 16 && cyc < 300) begin
         if (stalled) begin
            chk({tag, "_hold_valid"}, 32'(out_valid), 32'(1));
            chk({tag, "_hold_data"}, 32'(out_data), 32'(held));
            chk({tag, "_hold_last"}, 32'(out_last), 32'(held_last));
         end
         out_ready = bp ? tog : 1'b1;
         tog = ~tog;
         stalled = 1'b0;
         if (out_valid && out_ready) begin
            chk({tag, "_data"}, 32'(out_data), 32'(exp_q[k]));
            chk({tag, "_last"}, 32'(out_last), 32'(k == 15));
            k++;
         end else if (out_valid) begin
            stalled = 1'b1;
            held = out_data;
            held_last = out_last;
         end
         tick();
         cyc++;
      end
      out_ready = 1'b0;
      chk({tag, "_beats"}, 32'(k), 32'(16));
      chk({tag, "_end_valid"}, 32'(out_valid), 32'(0));
      chk({tag, "_end_busy"}, 32'(busy), 32'(0));
      chk({tag, "_end_trig"}, 32'(triggered), 32'(1));
   endtask

   initial begin
      rst = 1'b1; din = '0; din_valid = 1'b0; arm = 1'b0; trig_edge = 1'b0;
      force_trig = 1'b0; out_ready = 1'b0; trig_level = 8'h80;
      tick(); tick(); tick();
      chk("rst_valid", 32'(out_valid), 32'(0));
      chk("rst_last", 32'(out_last), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_trig", 32'(triggered), 32'(0));
      chk("rst_data", 32'(out_data), 32'(0));
      rst = 1'b0;
      tick();

      // Rising ramp, then the same frame read again under back-pressure
      for (int pass = 0; pass < 2; pass++) begin
         do_arm();
         chk("s1_busy", 32'(busy), 32'(1));
         for (int i = 0; i < 20; i++) begin
            sample(8'(i * 16));
            if (i == 7) chk("s1_pretrig", 32'(triggered), 32'(0));
            if (i == 8) chk("s1_trig", 32'(triggered), 32'(1));
         end
         for (int k = 0; k < 16; k++) exp_q[k] = 8'((4 + k) * 16);
         read_frame(pass == 0 ? "s1" : "s4", pass == 1);
      end

      // Crossing during pre-fill is ignored
      do_arm();
      sample(8'h00); sample(8'h90); sample(8'h00); sample(8'h00); sample(8'h00);
      chk("s2_no_trig", 32'(triggered), 32'(0));
      sample(8'h90);
      chk("s2_trig", 32'(triggered), 32'(1));
      for (int k = 0; k < 11; k++) sample(8'(8'hA0 + k));
      exp_q[0] = 8'h90; exp_q[1] = 8'h00; exp_q[2] = 8'h00; exp_q[3] = 8'h00; exp_q[4] = 8'h90;
      for (int k = 0; k < 11; k++) exp_q[5 + k] = 8'(8'hA0 + k);
      read_frame("s2", 1'b0);

      // Falling edge after the write pointer has wrapped
      trig_edge = 1'b1;
      do_arm();
      for (int i = 0; i < 40; i++) sample(8'hFF);
      chk("s3_no_trig", 32'(triggered), 32'(0));
      sample(8'h10);
      chk("s3_trig", 32'(triggered), 32'(1));
      for (int k = 0; k < 11; k++) sample(8'(8'h20 + k));
      for (int k = 0; k < 4; k++) exp_q[k] = 8'hFF;
      exp_q[4] = 8'h10;
      for (int k = 0; k < 11; k++) exp_q[5 + k] = 8'(8'h20 + k);
      read_frame("s3", 1'b0);
      trig_edge = 1'b0;

      // Forced trigger pulsed between samples, taken on the next one
      do_arm();
      for (int i = 0; i < 6; i++) sample(8'h20);
      force_trig = 1'b1;
      tick();
      force_trig = 1'b0;
      tick();
      chk("s5_pending", 32'(triggered), 32'(0));
      sample(8'h21);
      chk("s5_trig", 32'(triggered), 32'(1));
      for (int k = 0; k < 11; k++) sample(8'(8'h22 + k));
      for (int k = 0; k < 4; k++) exp_q[k] = 8'h20;
      exp_q[4] = 8'h21;
      for (int k = 0; k < 11; k++) exp_q[5 + k] = 8'(8'h22 + k);
      read_frame("s5", 1'b0);

      // Abort a stalled readout with arm, then reset in POST
      do_arm();
      for (int i = 0; i < 20; i++) sample(8'(i * 16));
      for (int w = 0; w < 10 && !out_valid; w++) tick();
      chk("s6_read_valid", 32'(out_valid), 32'(1));
      arm = 1'b1;
      tick();
      arm = 1'b0;
      chk("s6_abort_valid", 32'(out_valid), 32'(0));
      chk("s6_abort_busy", 32'(busy), 32'(1));
      chk("s6_abort_trig", 32'(triggered), 32'(0));
      tick();
      for (int i = 0; i < 4; i++) sample(8'h00);
      sample(8'h90);
      chk("s6_post_trig", 32'(triggered), 32'(1));
      sample(8'hA0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("s6_rst_valid", 32'(out_valid), 32'(0));
      chk("s6_rst_last", 32'(out_last), 32'(0));
      chk("s6_rst_busy", 32'(busy), 32'(0));
      chk("s6_rst_trig", 32'(triggered), 32'(0));
      chk("s6_rst_data", 32'(out_data), 32'(0));
      tick();
      sample(8'h55);
      chk("s6_idle_busy", 32'(busy), 32'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
